// File: rtl/filter_pkg.sv
// +----------------------------------------------------------------------+
// | filter_pkg : shared defaults and pixel types for the filter path      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package filter_pkg;

  localparam int C_PIX_W = 12;
  localparam int C_IMG_W = 320;
  localparam int C_IMG_H = 240;

  typedef logic [C_PIX_W-1:0] pixel_t;

  // RGB444 field positions within a pixel
  localparam int C_R_HI = 11;
  localparam int C_R_LO = 8;
  localparam int C_G_HI = 7;
  localparam int C_G_LO = 4;
  localparam int C_B_HI = 3;
  localparam int C_B_LO = 0;

endpackage

`default_nettype wire

// File: rtl/window_gen_3x3_line_buffer.sv
// +----------------------------------------------------------------------+
// | line_buffer : simple dual-port line RAM, registered read-first port   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // No reset on storage or read register so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/window_gen_3x3.sv
// +----------------------------------------------------------------------+
// | window_gen_3x3 : streaming 3x3 neighbourhood generator, RGB444 pixels |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module window_gen_3x3
  import filter_pkg::*;
#(
  parameter int PIX_W = C_PIX_W,
  parameter int IMG_W = C_IMG_W,
  parameter int IMG_H = C_IMG_H
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_sof,
  input  logic                     i_valid,
  input  logic [PIX_W-1:0]         i_pixel,
  output logic                     o_valid,
  output logic                     o_border,
  output logic [$clog2(IMG_W)-1:0] o_x,
  output logic [$clog2(IMG_H)-1:0] o_y,
  output logic [PIX_W-1:0]         PixelData_00,
  output logic [PIX_W-1:0]         PixelData_01,
  output logic [PIX_W-1:0]         PixelData_02,
  output logic [PIX_W-1:0]         PixelData_10,
  output logic [PIX_W-1:0]         PixelData_11,
  output logic [PIX_W-1:0]         PixelData_12,
  output logic [PIX_W-1:0]         PixelData_20,
  output logic [PIX_W-1:0]         PixelData_21,
  output logic [PIX_W-1:0]         PixelData_22
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] C_X_TWO  = XW'(2);
  localparam logic [YW-1:0] C_Y_TWO  = YW'(2);

  logic [XW-1:0]    r_x, w_x_cur, w_x_nxt;
  logic [YW-1:0]    r_y, w_y_cur, w_y_nxt;
  logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd;
  logic [PIX_W-1:0] r_win [3][3];
  logic             r_valid, r_border;
  logic [XW-1:0]    r_out_x;
  logic [YW-1:0]    r_out_y;

  // A start-of-frame strobe overrides the running position for this cycle
  always_comb begin
    w_x_cur = i_sof ? '0 : r_x;
    w_y_cur = i_sof ? '0 : r_y;
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (i_valid) begin
      if (w_x_cur == C_X_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (w_y_cur == C_Y_LAST) ? '0 : w_y_cur + 1'b1;
      end else begin
        w_x_nxt = w_x_cur + 1'b1;
        w_y_nxt = w_y_cur;
      end
    end else if (i_sof) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end
  end

  // Read at next-x so the registered RAM output lines up with the next accept
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk       (clk),
    .i_wr_en   (i_valid),
    .i_wr_addr (w_x_cur),
    .i_wr_data (i_pixel),
    .i_rd_addr (w_x_nxt),
    .o_rd_data (w_lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk       (clk),
    .i_wr_en   (i_valid),
    .i_wr_addr (w_x_cur),
    .i_wr_data (w_lb0_rd),
    .i_rd_addr (w_x_nxt),
    .o_rd_data (w_lb1_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_border <= 1'b0;
      r_out_x  <= '0;
      r_out_y  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_valid <= i_valid;
      if (i_valid) begin
        r_border <= (w_x_cur < C_X_TWO) || (w_y_cur < C_Y_TWO);
        r_out_x  <= (w_x_cur == '0) ? C_X_LAST : w_x_cur - 1'b1;
        r_out_y  <= (w_y_cur == '0) ? C_Y_LAST : w_y_cur - 1'b1;
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb1_rd;
        r_win[1][2] <= w_lb0_rd;
        r_win[2][2] <= i_pixel;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_border     = r_border;
  assign o_x          = r_out_x;
  assign o_y          = r_out_y;
  assign PixelData_00 = r_win[0][0];
  assign PixelData_01 = r_win[0][1];
  assign PixelData_02 = r_win[0][2];
  assign PixelData_10 = r_win[1][0];
  assign PixelData_11 = r_win[1][1];
  assign PixelData_12 = r_win[1][2];
  assign PixelData_20 = r_win[2][0];
  assign PixelData_21 = r_win[2][1];
  assign PixelData_22 = r_win[2][2];

endmodule

`default_nettype wire
